// File: rtl/alu_issue_stage.sv
// Decode/operand-select stage feeding the ALU, with a 2-entry skid buffer on the output side.
// Optional macro ALU_ISSUE_BRANCH_EN adds BRANCH decode and the out_branch port.
module alu_issue_stage #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_instr,
  input  logic [N-1:0] in_pc,
  input  logic [N-1:0] in_rs1,
  input  logic [N-1:0] in_rs2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output logic [3:0]   out_control,
  output logic [4:0]   out_rd,
  output logic         out_illegal,
`ifdef ALU_ISSUE_BRANCH_EN
  output logic         out_branch,
`endif
  output logic [1:0]   dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready depends only on occupancy; out_* stay stable while out_valid & ~out_ready.

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'(DEPTH);

  localparam logic [3:0] C_AND  = 4'b0001;
  localparam logic [3:0] C_OR   = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0101;
  localparam logic [3:0] C_SRL  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_ADD  = 4'b1000;
  localparam logic [3:0] C_SUB  = 4'b1100;
  localparam logic [3:0] C_SLT  = 4'b1101;
  localparam logic [3:0] C_SLTU = 4'b1111;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ctrl;
    logic [4:0]   rd;
    logic         illegal;
`ifdef ALU_ISSUE_BRANCH_EN
    logic         branch;
`endif
  } entry_t;

  logic [1:0] state_q, state_d;
  logic       init_q;
  entry_t     e0_q, e0_d, e1_q, e1_d;
  entry_t     dec;
  logic       dec_ok;
  logic       push, pop;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_rs1_field;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign unused_rs1_field = ^in_instr[19:15];

  function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_ctrl = C_ADD;
      3'b001:  f3_ctrl = C_SLL;
      3'b010:  f3_ctrl = C_SLT;
      3'b011:  f3_ctrl = C_SLTU;
      3'b100:  f3_ctrl = C_XOR;
      3'b101:  f3_ctrl = C_SRL;
      3'b110:  f3_ctrl = C_OR;
      default: f3_ctrl = C_AND;
    endcase
  endfunction

  always_comb begin
    dec      = '0;
    dec_ok   = 1'b1;
    dec.rd   = in_instr[11:7];
    dec.ctrl = C_ADD;
    case (opcode)
      7'b0110011: begin
        dec.a = in_rs1;
        dec.b = in_rs2;
        if (funct7 == 7'b0000000) begin
          dec.ctrl = f3_ctrl(funct3);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.ctrl = C_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.ctrl = C_SRA;
        end else begin
          dec_ok = 1'b0;
        end
      end
      7'b0010011: begin
        dec.a = in_rs1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shifts take only the 5-bit shamt; funct7 selects SRL vs SRA.
          dec.b = {27'b0, in_instr[24:20]};
          if (funct3 == 3'b001) begin
            dec.ctrl = C_SLL;
            dec_ok   = (funct7 == 7'b0000000);
          end else if (funct7 == 7'b0000000) begin
            dec.ctrl = C_SRL;
          end else if (funct7 == 7'b0100000) begin
            dec.ctrl = C_SRA;
          end else begin
            dec_ok = 1'b0;
          end
        end else begin
          dec.b    = {{20{in_instr[31]}}, in_instr[31:20]};
          dec.ctrl = f3_ctrl(funct3);
        end
      end
      7'b0110111: begin
        dec.a = '0;
        dec.b = {in_instr[31:12], 12'b0};
      end
      7'b0010111: begin
        dec.a = in_pc;
        dec.b = {in_instr[31:12], 12'b0};
      end
`ifdef ALU_ISSUE_BRANCH_EN
      7'b1100011: begin
        dec.a = in_rs1;
        dec.b = in_rs2;
        case (funct3)
          3'b000, 3'b001: dec.ctrl = C_SUB;
          3'b100, 3'b101: dec.ctrl = C_SLT;
          3'b110, 3'b111: dec.ctrl = C_SLTU;
          default:        dec_ok   = 1'b0;
        endcase
        if (dec_ok) begin
          dec.rd     = 5'd0;
          dec.branch = 1'b1;
        end
      end
`endif
      default: dec_ok = 1'b0;
    endcase
    if (!dec_ok) begin
      dec.a       = '0;
      dec.b       = '0;
      dec.ctrl    = C_ADD;
      dec.illegal = 1'b1;
`ifdef ALU_ISSUE_BRANCH_EN
      dec.branch  = 1'b0;
`endif
    end
  end

  // init_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = init_q & (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          e0_d    = dec;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          e0_d = dec;
        end else if (push) begin
          e1_d    = dec;
          state_d = S_FULL;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          e0_d    = e1_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      init_q  <= 1'b0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign out_a       = e0_q.a;
  assign out_b       = e0_q.b;
  assign out_control = e0_q.ctrl;
  assign out_rd      = e0_q.rd;
  assign out_illegal = e0_q.illegal;
`ifdef ALU_ISSUE_BRANCH_EN
  assign out_branch  = e0_q.branch;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/operand-select stage directly upstream of the ALU.
- Accepts one RV32I instruction per cycle, with PC and register-file read data, over a valid/ready handshake.
- Decodes the ALU operation and selects operands a/b.
- Buffers results in a 2-entry skid buffer, so the ALU/writeback side can stall without dropping instructions.
- Outputs drive the ALU a, b and control inputs directly.

Parameters:
N, 32, data width; only 32 is supported.
DEPTH, 2, skid-buffer entries; fixed at 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
in_valid  input  1  upstream has an instruction.
in_ready  output  1  stage can accept an instruction this cycle.
in_instr  input  32  RV32I instruction word.
in_pc  input  32  PC of in_instr.
in_rs1  input  32  rs1 read data.
in_rs2  input  32  rs2 read data.
out_valid  output  1  head entry is valid.
out_ready  input  1  downstream consumes head this cycle.
out_a  output  32  ALU operand a.
out_b  output  32  ALU operand b.
out_control  output  4  alu_control_t.
out_rd  output  5  destination register, instr[11:7].
out_illegal  output  1  head instruction is not supported.

Behaviour:
- alu_control_t encodings:
  - AND 0001, OR 0010, XOR 0011.
  - SLL 0101, SRL 0110, SRA 0111.
  - ADD 1000, SUB 1100, SLT 1101, SLTU 1111.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Occupancy and readiness:
  - Occupancy count is 0..2; states are EMPTY, ONE, FULL.
  - in_ready = (count != 2). It depends on state only and never on out_ready.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE, with the new entry becoming head the next cycle.
  - FULL: pop -> ONE. No push is possible (in_ready=0).
- Latency and ordering:
  - An instruction accepted in cycle t appears on out_* in cycle t+1 when the stage was EMPTY, or when it was ONE with a simultaneous pop.
  - Order is strictly FIFO.
  - out_* hold stable while out_valid & ~out_ready.
- Decode, by opcode instr[6:0]:
  - OP 0110011:
    - a=rs1, b=rs2.
    - funct3 000/001/010/011/100/101/110/111 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
    - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
    - Any other funct7 is illegal.
  - OP-IMM 0010011:
    - a=rs1, b = sign-extended instr[31:20].
    - For funct3 001/101: b = {27'b0, instr[24:20]}.
    - funct3 001 requires instr[31:25]=0.
    - funct3 101 requires instr[31:25] of 0000000 (SRL) or 0100000 (SRA).
    - There is no SUB form.
  - LUI 0110111: a=0, b={instr[31:12],12'b0}, ADD.
  - AUIPC 0010111: a=pc, b={instr[31:12],12'b0}, ADD.
  - Other opcodes, or any violated funct rule: out_illegal=1, a=0, b=0, control=ADD. The entry still flows through the buffer normally.
- Operand capture: operands are captured at push time. Later changes on in_rs1/in_rs2 do not affect a stored entry.
- Reset, asserted asynchronously:
  - count=0, out_valid=0, in_ready=0 while rst is low.
  - All stored a/b/control/rd/illegal = 0.
  - After deassertion, in_ready=1 at the first clock edge.
  - Reset mid-operation discards all entries with no partial output.

Optional Feature:
- Macro: ALU_ISSUE_BRANCH_EN.
- When defined:
  - Adds output port out_branch (1 bit).
  - BRANCH opcode 1100011 is decoded with a=rs1, b=rs2:
    - funct3 000/001 (BEQ/BNE) -> SUB.
    - funct3 100/101 (BLT/BGE) -> SLT.
    - funct3 110/111 (BLTU/BGEU) -> SLTU.
    - funct3 010/011 -> illegal.
  - out_rd is 0 for branches.
  - out_branch=1 for legal branches, otherwise 0; it resets to 0.
- When undefined: the port is absent and 1100011 is illegal.

Test Plan:
- Reset: hold rst low with in_valid=1 -> in_ready=0, out_valid=0; release -> in_ready=1 next edge.
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, a=5, b=7, control=1000, rd=3, illegal=0.
- SRAI x1,x1,4 (0x4040D093), rs1=0x80000000 -> b=4, control=0111. ADDI imm=-1 -> b=0xFFFFFFFF, control=1000.
- Backpressure: out_ready=0, push 3 back-to-back -> after 2 accepted, in_ready=0 and the third is held. Raise out_ready -> the three emerge in order with no loss or duplication.
- Simultaneous push+pop in ONE for 10 cycles -> count stays 1, one output per cycle. Illegal opcode 0x0000000F mid-stream -> out_illegal=1, a=b=0, neighbours unaffected.
- With ALU_ISSUE_BRANCH_EN: BLTU (0x0020E463) -> control=1111, out_branch=1, rd=0. Without the macro -> out_illegal=1.
